trivium_ks_xor: RTL

//   Downstream stage of the Trivium keystream generator. Accepts one keystream

---
 rtl/trivium_ks_xor.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/trivium_ks_xor.sv
// trivium_ks_xor
//   Takes one Trivium keystream block and XORs it byte by byte onto a
//   plaintext byte stream. The result leaves on a valid/ready byte stream
//   with a last flag. Decryption uses exactly the same datapath.
//
//   Ports
//     clk, reset            rising-edge clock; asynchronous active-low reset
//     ks_in/ks_len          keystream block (bit 0 first) and its valid bit count
//     ks_valid/ks_ready     keystream handshake; a block is taken only in IDLE
//     pt_data/pt_last       plaintext byte and end-of-message flag
//     pt_valid/pt_ready     plaintext handshake
//     ct_data/ct_last       ciphertext byte and end-of-message flag
//     ct_valid/ct_ready     ciphertext handshake
//     busy                  high whenever a block is being consumed or drained
//     err_short             sticky: the keystream ran out before pt_last
module trivium_ks_xor #(
    parameter int KS_W  = 512,
    parameter int LEN_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KS_W-1:0]  ks_in,
    input  logic [LEN_W-1:0] ks_len,
    input  logic             ks_valid,
    output logic             ks_ready,
    input  logic [7:0]       pt_data,
    input  logic             pt_valid,
    input  logic             pt_last,
    output logic             pt_ready,
    output logic [7:0]       ct_data,
    output logic             ct_valid,
    output logic             ct_last,
    input  logic             ct_ready,
    output logic             busy,
    output logic             err_short
);

    localparam int NB    = KS_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int CNT_W = $clog2(NB + 1);
    localparam logic [LEN_W:0] KS_W_CAP = (LEN_W + 1)'(KS_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_reg;
    logic [KS_W-1:0]   ks_buf_reg;
    logic [CNT_W-1:0]  idx_reg;
    logic [CNT_W-1:0]  nbytes_reg;
    logic              ks_ready_reg;
    logic [7:0]        ct_data_reg;
    logic              ct_valid_reg;
    logic              ct_last_reg;
    logic              err_short_reg;

    // Byte view of the latched keystream block.
    logic [7:0] ks_bytes [NB];

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_ks_bytes
            assign ks_bytes[gi] = ks_buf_reg[8*gi +: 8];
        end
    endgenerate

    // Usable whole bytes: the length is clamped to the block width first,
    // and any trailing partial byte is dropped.
    logic [LEN_W:0]   ks_len_ext;
    logic [LEN_W:0]   ks_cap;
    logic [CNT_W-1:0] nbytes_calc;

    assign ks_len_ext  = {1'b0, ks_len};
    assign ks_cap      = (ks_len_ext > KS_W_CAP) ? KS_W_CAP : ks_len_ext;
    assign nbytes_calc = CNT_W'(ks_cap >> 3);

    logic ks_fire;
    logic pt_fire;
    logic ct_fire;
    logic last_byte;

    // The single output register can take a new byte whenever it is empty
    // or is being drained in this same cycle.
    assign pt_ready  = (state_reg == RUN) && (!ct_valid_reg || ct_ready);
    assign ks_fire   = ks_valid && ks_ready_reg;
    assign pt_fire   = pt_valid && pt_ready;
    assign ct_fire   = ct_valid_reg && ct_ready;
    assign last_byte = (idx_reg == nbytes_reg - CNT_W'(1));

    assign ks_ready  = ks_ready_reg;
    assign ct_data   = ct_data_reg;
    assign ct_valid  = ct_valid_reg;
    assign ct_last   = ct_last_reg;
    assign err_short = err_short_reg;
    assign busy      = (state_reg != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            ks_buf_reg    <= '0;
            idx_reg       <= '0;
            nbytes_reg    <= '0;
            ks_ready_reg  <= 1'b0;
            ct_data_reg   <= 8'h00;
            ct_valid_reg  <= 1'b0;
            ct_last_reg   <= 1'b0;
            err_short_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ks_ready_reg <= 1'b1;
                    if (ks_fire) begin
                        ks_buf_reg    <= ks_in;
                        nbytes_reg    <= nbytes_calc;
                        idx_reg       <= '0;
                        err_short_reg <= 1'b0;
                        // A block with no whole byte is accepted and dropped.
                        if (nbytes_calc != '0) begin
                            state_reg    <= RUN;
                            ks_ready_reg <= 1'b0;
                        end
                    end
                end

                RUN: begin
                    if (pt_fire) begin
                        ct_data_reg  <= pt_data ^ ks_bytes[idx_reg[IDX_W-1:0]];
                        ct_valid_reg <= 1'b1;
                        ct_last_reg  <= pt_last || last_byte;
                        idx_reg      <= idx_reg + CNT_W'(1);
                        if (pt_last || last_byte) begin
                            state_reg <= DRAIN;
                        end
                        if (last_byte && !pt_last) begin
                            err_short_reg <= 1'b1;
                        end
                    end else if (ct_fire) begin
                        ct_valid_reg <= 1'b0;
                    end
                end

                DRAIN: begin
                    // The held byte is the message's last one.
                    if (ct_fire) begin
                        ct_valid_reg <= 1'b0;
                        state_reg    <= IDLE;
                        ks_ready_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
